// File: rtl/regfile_dp_param.sv
// WIDTH x DEPTH register file: one write port, two registered read ports with write bypass, and a clear sequencer.
// Optional per-entry even parity with error injection is enabled by defining REGFILE_PARITY_EN.
module regfile_dp_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en1,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    output logic             rd_valid1,
    input  logic             rd_en2,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_valid2,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
`ifdef REGFILE_PARITY_EN
    ,
    input  logic             inj_perr,
    output logic             rd_perr1,
    output logic             rd_perr2
`endif
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             busy_w, wr_commit, byp1, byp2, in1, in2;
    logic             rd_valid1_q, rd_valid1_d, rd_valid2_q, rd_valid2_d;
    logic [WIDTH-1:0] rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
    logic             wr_drop_q, wr_drop_d;

    assign busy_w    = (state_q == ST_CLEAR);
    assign wr_commit = !busy_w && wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign wr_drop_d = wr_en && !wr_commit;
    assign in1       = ({1'b0, rd_addr1} < DEPTH_W);
    assign in2       = ({1'b0, rd_addr2} < DEPTH_W);
    assign byp1      = wr_commit && (wr_addr == rd_addr1);
    assign byp2      = wr_commit && (wr_addr == rd_addr2);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Storage has no reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (busy_w) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_commit) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_valid1_d = !busy_w && rd_en1;
        rd_data1_d  = '0;
        if (rd_valid1_d && in1) begin
            rd_data1_d = byp1 ? wr_data : mem_q[rd_addr1];
        end
        rd_valid2_d = !busy_w && rd_en2;
        rd_data2_d  = '0;
        if (rd_valid2_d && in2) begin
            rd_data2_d = byp2 ? wr_data : mem_q[rd_addr2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
            rd_valid2_q <= 1'b0;
            rd_data2_q  <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_valid1_q <= rd_valid1_d;
            rd_data1_q  <= rd_data1_d;
            rd_valid2_q <= rd_valid2_d;
            rd_data2_q  <= rd_data2_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    assign busy      = busy_w;
    assign wr_drop   = wr_drop_q;
    assign rd_valid1 = rd_valid1_q;
    assign rd_data1  = rd_data1_q;
    assign rd_valid2 = rd_valid2_q;
    assign rd_data2  = rd_data2_q;

`ifdef REGFILE_PARITY_EN
    logic par_q [DEPTH];
    logic perr1_q, perr1_d, perr2_q, perr2_d;

    // Clear writes parity 0, which is the correct even parity of all-zero data.
    always_ff @(posedge clk) begin
        if (busy_w) begin
            par_q[ptr_q] <= 1'b0;
        end else if (wr_commit) begin
            par_q[wr_addr] <= (^wr_data) ^ inj_perr;
        end
    end

    always_comb begin
        perr1_d = 1'b0;
        perr2_d = 1'b0;
        if (rd_valid1_d && in1 && !byp1) begin
            perr1_d = (^mem_q[rd_addr1]) != par_q[rd_addr1];
        end
        if (rd_valid2_d && in2 && !byp2) begin
            perr2_d = (^mem_q[rd_addr2]) != par_q[rd_addr2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr1_q <= 1'b0;
            perr2_q <= 1'b0;
        end else begin
            perr1_q <= perr1_d;
            perr2_q <= perr2_d;
        end
    end

    assign rd_perr1 = perr1_q;
    assign rd_perr2 = perr2_q;
`endif

endmodule
